// File: rtl/spi_cmd_sequencer_pkg.sv
// rtl/spi_cmd_sequencer_pkg.sv - opcode/state types and argument counts for the SPI command sequencer
//
// Purpose: shared types for spi_cmd_sequencer.
//   opcode_e : command opcodes carried in cmd byte [7:4]
//   state_e  : sequencer FSM states
//   ARGS_*   : number of argument bytes following each opcode
package spi_cmd_pkg;

  typedef enum logic [3:0] {
    WRITE_AT   = 4'h8,
    READ_AT    = 4'h2,
    READ_NEXT  = 4'h3,
    WRITE_NEXT = 4'h4
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ARG,
    BUS,
    DONE,
    ERROR
  } state_e;

  localparam logic [1:0] ARGS_WRITE_AT   = 2'd3;
  localparam logic [1:0] ARGS_READ_AT    = 2'd2;
  localparam logic [1:0] ARGS_READ_NEXT  = 2'd0;
  localparam logic [1:0] ARGS_WRITE_NEXT = 2'd1;

  function automatic logic op_is_valid(input logic [3:0] op);
    return (op == WRITE_AT) || (op == READ_AT) || (op == READ_NEXT) || (op == WRITE_NEXT);
  endfunction

  function automatic logic [1:0] op_arg_count(input logic [3:0] op);
    case (op)
      WRITE_AT:   return ARGS_WRITE_AT;
      READ_AT:    return ARGS_READ_AT;
      WRITE_NEXT: return ARGS_WRITE_NEXT;
      default:    return ARGS_READ_NEXT;
    endcase
  endfunction

  function automatic logic op_is_write(input opcode_e op);
    return (op == WRITE_AT) || (op == WRITE_NEXT);
  endfunction

  // Full 17-bit address: A16 from the command byte, then the two argument bytes.
  function automatic logic [16:0] join_addr(input logic a16, input logic [7:0] hi, input logic [7:0] lo);
    return {a16, hi, lo};
  endfunction

endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// rtl/spi_cmd_sequencer_if.sv - SPI byte-side and bus-side signal bundle for spi_cmd_sequencer
//
// Purpose: groups the spi_byte handshake and the simple strobe/ack bus.
//   spi_cs_ni, rx_byte_i, rx_valid_i, tx_byte_o : byte-level SPI side
//   addr_o, data_o, data_i, we_o, strobe_o, ack_i, busy_o : bus side
//   modport master : the sequencer
//   modport slave  : the environment (spi_byte + bus target)
interface spi_cmd_sequencer_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 8
);

  logic                  spi_cs_ni;
  logic [7:0]            rx_byte_i;
  logic                  rx_valid_i;
  logic [7:0]            tx_byte_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  we_o;
  logic                  strobe_o;
  logic                  ack_i;
  logic                  busy_o;

  modport master (
    input  spi_cs_ni, rx_byte_i, rx_valid_i, data_i, ack_i,
    output tx_byte_o, addr_o, data_o, we_o, strobe_o, busy_o
  );

  modport slave (
    output spi_cs_ni, rx_byte_i, rx_valid_i, data_i, ack_i,
    input  tx_byte_o, addr_o, data_o, we_o, strobe_o, busy_o
  );

endinterface

// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - decodes SPI command bytes into single bus read/write cycles
//
// Purpose: collects a command byte plus its arguments from spi_byte, issues one
// strobe/ack bus cycle per command, and returns read data through tx_byte_o.
// Ports:
//   clk_sys_i : system clock, rising edge
//   reset_i   : asynchronous active-high reset
//   bus       : spi_cmd_sequencer_if.master (SPI byte side + bus side)
module spi_cmd_sequencer
  import spi_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_sys_i,
  input  logic                  reset_i,
  spi_cmd_sequencer_if.master   bus
);

  state_e                state;
  opcode_e               op_q;
  logic                  a16_q;
  logic [1:0]            arg_cnt;
  logic [7:0]            data_buf;
  logic [7:0]            addr_hi_buf;
  logic                  cs_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [7:0]            tx_q;
  logic                  we_q;
  logic                  strobe_q;
  logic                  busy_q;

  logic       cs_fall;
  logic       cs_high;
  logic [3:0] rx_op;

  assign cs_fall = cs_q & ~bus.spi_cs_ni;
  assign cs_high = bus.spi_cs_ni;
  assign rx_op   = bus.rx_byte_i[7:4];

  assign bus.addr_o    = addr_q;
  assign bus.data_o    = data_q;
  assign bus.tx_byte_o = tx_q;
  assign bus.we_o      = we_q;
  assign bus.strobe_o  = strobe_q;
  assign bus.busy_o    = busy_q;

  always_ff @(posedge clk_sys_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      op_q        <= READ_NEXT;
      a16_q       <= 1'b0;
      arg_cnt     <= 2'd0;
      data_buf    <= 8'h00;
      addr_hi_buf <= 8'h00;
      cs_q        <= 1'b1;
      addr_q      <= '0;
      data_q      <= '0;
      tx_q        <= 8'h00;
      we_q        <= 1'b0;
      strobe_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cs_q <= bus.spi_cs_ni;
      case (state)
        IDLE: begin
          if (cs_fall) state <= CMD;
        end

        // DONE accepts the next command byte exactly like CMD, so commands chain within one frame.
        CMD, DONE: begin
          if (cs_high) begin
            state <= IDLE;
          end else if (bus.rx_valid_i) begin
            if (!op_is_valid(rx_op)) begin
              state <= ERROR;
            end else begin
              op_q    <= opcode_e'(rx_op);
              a16_q   <= bus.rx_byte_i[0];
              arg_cnt <= op_arg_count(rx_op);
              if (op_arg_count(rx_op) == 2'd0) begin
                addr_q   <= addr_q + ADDR_WIDTH'(1);
                we_q     <= op_is_write(opcode_e'(rx_op));
                strobe_q <= 1'b1;
                busy_q   <= 1'b1;
                state    <= BUS;
              end else begin
                state <= ARG;
              end
            end
          end
        end

        // Arguments land in shadow buffers; addr_q/data_q only change on the final byte,
        // so a frame cut short by CS leaves the visible bus registers untouched.
        ARG: begin
          if (cs_high) begin
            state <= IDLE;
          end else if (bus.rx_valid_i) begin
            arg_cnt <= arg_cnt - 2'd1;
            if (arg_cnt == 2'd1) begin
              case (op_q)
                WRITE_AT: begin
                  addr_q <= ADDR_WIDTH'(join_addr(a16_q, addr_hi_buf, bus.rx_byte_i));
                  data_q <= DATA_WIDTH'(data_buf);
                end
                READ_AT: begin
                  addr_q <= ADDR_WIDTH'(join_addr(a16_q, addr_hi_buf, bus.rx_byte_i));
                end
                WRITE_NEXT: begin
                  addr_q <= addr_q + ADDR_WIDTH'(1);
                  data_q <= DATA_WIDTH'(bus.rx_byte_i);
                end
                default: ;
              endcase
              we_q     <= op_is_write(op_q);
              strobe_q <= 1'b1;
              busy_q   <= 1'b1;
              state    <= BUS;
            end else if (op_q == WRITE_AT && arg_cnt == ARGS_WRITE_AT) begin
              data_buf <= bus.rx_byte_i;
            end else begin
              addr_hi_buf <= bus.rx_byte_i;
            end
          end
        end

        // CS is deliberately not checked here until ack: the cycle must complete.
        BUS: begin
          if (bus.ack_i) begin
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            if (!we_q) tx_q <= 8'(bus.data_i);
            state <= cs_high ? IDLE : DONE;
          end
        end

        ERROR: begin
          if (cs_high) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb/tb_spi_cmd_sequencer.sv - self-checking bench for spi_cmd_sequencer
module tb_spi_cmd_sequencer;
  import spi_cmd_pkg::*;

  logic clk_sys_i = 1'b0;
  logic reset_i;

  always #5 clk_sys_i = ~clk_sys_i;

  spi_cmd_sequencer_if #(.ADDR_WIDTH(17), .DATA_WIDTH(8)) bus_if ();

  spi_cmd_sequencer #(.ADDR_WIDTH(17), .DATA_WIDTH(8)) dut (
    .clk_sys_i (clk_sys_i),
    .reset_i   (reset_i),
    .bus       (bus_if)
  );

  int n_total = 0;
  int n_pass  = 0;

  logic [16:0] m_addr;
  logic [7:0]  m_data;
  logic [7:0]  m_tx;

  typedef struct packed {
    logic [31:0] bytes;
    logic [2:0]  n;
    logic [7:0]  rd;
    logic [16:0] addr;
    logic        we;
    logic [7:0]  data;
    logic [7:0]  tx;
  } vec_t;

  vec_t vt[6];

  logic [3:0] bad_ops[12] = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic cs_low();
    @(negedge clk_sys_i);
    bus_if.spi_cs_ni = 1'b0;
    repeat (2) @(negedge clk_sys_i);
  endtask

  task automatic cs_high();
    @(negedge clk_sys_i);
    bus_if.spi_cs_ni = 1'b1;
    repeat (2) @(negedge clk_sys_i);
  endtask

  task automatic send(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(negedge clk_sys_i);
    bus_if.rx_byte_i  = b;
    bus_if.rx_valid_i = 1'b1;
    @(negedge clk_sys_i);
    bus_if.rx_valid_i = 1'b0;
    bus_if.rx_byte_i  = 8'($urandom);
  endtask

  // Called at the negedge right after the final byte's rx_valid edge.
  task automatic serve_bus(input string tag, input logic [16:0] e_addr, input logic e_we,
                           input logic [7:0] e_data, input int delay, input logic [7:0] rdata,
                           input bit inject, input bit cs_rise);
    check({tag, "_strobe_rise"}, 32'(bus_if.strobe_o), 32'd1);
    check({tag, "_busy"},        32'(bus_if.busy_o),   32'd1);
    check({tag, "_addr"},        32'(bus_if.addr_o),   32'(e_addr));
    check({tag, "_we"},          32'(bus_if.we_o),     32'(e_we));
    check({tag, "_data"},        32'(bus_if.data_o),   32'(e_data));
    for (int i = 0; i < delay; i++) begin
      if (i == 0 && inject) begin
        bus_if.rx_byte_i  = 8'($urandom);
        bus_if.rx_valid_i = 1'b1;
      end
      if (i == 0 && cs_rise) bus_if.spi_cs_ni = 1'b1;
      @(negedge clk_sys_i);
      bus_if.rx_valid_i = 1'b0;
      check({tag, "_strobe_held"}, 32'(bus_if.strobe_o), 32'd1);
    end
    bus_if.ack_i  = 1'b1;
    bus_if.data_i = rdata;
    @(negedge clk_sys_i);
    bus_if.ack_i  = 1'b0;
    bus_if.data_i = 8'($urandom);
    check({tag, "_strobe_drop"}, 32'(bus_if.strobe_o), 32'd0);
    check({tag, "_busy_drop"},   32'(bus_if.busy_o),   32'd0);
    if (cs_rise) check({tag, "_idle_after_ack"}, 32'(dut.state), 32'(IDLE));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ncmd, k, nargs, nsend, delay, nj;
    bit ended, trunc, cs_rise, inject, e_we;
    logic [3:0] op;
    logic a16;
    logic [7:0] cmdb, rd;
    logic [7:0] args[3];

    reset_i           = 1'b1;
    bus_if.spi_cs_ni  = 1'b1;
    bus_if.rx_byte_i  = 8'h00;
    bus_if.rx_valid_i = 1'b0;
    bus_if.data_i     = 8'h00;
    bus_if.ack_i      = 1'b0;
    repeat (3) @(negedge clk_sys_i);
    reset_i = 1'b0;
    @(negedge clk_sys_i);

    check("rst_state",  32'(dut.state),          32'(IDLE));
    check("rst_strobe", 32'(bus_if.strobe_o),    32'd0);
    check("rst_we",     32'(bus_if.we_o),        32'd0);
    check("rst_busy",   32'(bus_if.busy_o),      32'd0);
    check("rst_addr",   32'(bus_if.addr_o),      32'd0);
    check("rst_data",   32'(bus_if.data_o),      32'd0);
    check("rst_tx",     32'(bus_if.tx_byte_o),   32'd0);

    // bytes (left-aligned), count, read data on ack, expected addr/we/data, tx after ack
    vt[0] = '{32'h815A1234, 3'd4, 8'h66, 17'h11234, 1'b1, 8'h5A, 8'h00};
    vt[1] = '{32'h20800000, 3'd3, 8'hC3, 17'h08000, 1'b0, 8'h5A, 8'hC3};
    vt[2] = '{32'h81EEFFFF, 3'd4, 8'h99, 17'h1FFFF, 1'b1, 8'hEE, 8'hC3};
    vt[3] = '{32'h40770000, 3'd2, 8'h55, 17'h00000, 1'b1, 8'h77, 8'hC3};
    vt[4] = '{32'h30000000, 3'd1, 8'h9D, 17'h00001, 1'b0, 8'h77, 8'h9D};
    vt[5] = '{32'h2FABCD00, 3'd3, 8'h11, 17'h1ABCD, 1'b0, 8'h77, 8'h11};

    for (int i = 0; i < 6; i++) begin
      cs_low();
      for (int j = 0; j < int'(vt[i].n); j++) begin
        send(vt[i].bytes[31 - 8*j -: 8]);
        if (j < int'(vt[i].n) - 1) check("vec_no_early_strobe", 32'(bus_if.strobe_o), 32'd0);
      end
      serve_bus("vec", vt[i].addr, vt[i].we, vt[i].data, i % 3, vt[i].rd, 1'b0, 1'b0);
      check("vec_tx", 32'(bus_if.tx_byte_o), 32'(vt[i].tx));
      cs_high();
    end

    // Partial WRITE_AT aborted by CS: nothing issued, address kept for READ_NEXT.
    cs_low();
    send(8'h81);
    send(8'h5A);
    cs_high();
    check("abort_no_strobe", 32'(bus_if.strobe_o), 32'd0);
    check("abort_state",     32'(dut.state),       32'(IDLE));
    check("abort_addr_kept", 32'(bus_if.addr_o),   32'h1ABCD);
    check("abort_data_kept", 32'(bus_if.data_o),   32'h77);
    cs_low();
    send(8'h30);
    serve_bus("rn_after_abort", 17'h1ABCE, 1'b0, 8'h77, 0, 8'h3C, 1'b0, 1'b0);
    check("rn_after_abort_tx", 32'(bus_if.tx_byte_o), 32'h3C);

    // Chained commands in the same frame (state DONE accepts a new command).
    send(8'h30);
    serve_bus("chain_rn", 17'h1ABCF, 1'b0, 8'h77, 1, 8'h01, 1'b0, 1'b0);
    send(8'h40);
    check("chain_no_early_strobe", 32'(bus_if.strobe_o), 32'd0);
    send(8'h42);
    serve_bus("chain_wn", 17'h1ABD0, 1'b1, 8'h42, 2, 8'hF7, 1'b0, 1'b0);
    check("chain_tx", 32'(bus_if.tx_byte_o), 32'h01);
    cs_high();

    // Illegal opcode: bytes ignored until CS rises.
    cs_low();
    send(8'hF0);
    for (int j = 0; j < 3; j++) begin
      send(8'h81);
      check("err_no_strobe", 32'(bus_if.strobe_o), 32'd0);
    end
    check("err_state", 32'(dut.state), 32'(ERROR));
    cs_high();
    check("err_to_idle", 32'(dut.state), 32'(IDLE));

    // CS rises during a bus cycle with a slow ack; a stray rx pulse in BUS is dropped.
    cs_low();
    send(8'h20);
    send(8'h12);
    send(8'h34);
    serve_bus("cs_in_bus", 17'h01234, 1'b0, 8'h42, 5, 8'h5E, 1'b1, 1'b1);
    check("cs_in_bus_tx", 32'(bus_if.tx_byte_o), 32'h5E);

    // Reset in the middle of a strobe, then a late ack that must be ignored.
    cs_low();
    send(8'h81);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    check("pre_reset_strobe", 32'(bus_if.strobe_o), 32'd1);
    #2 reset_i = 1'b1;
    #1;
    check("async_reset_strobe", 32'(bus_if.strobe_o), 32'd0);
    check("async_reset_busy",   32'(bus_if.busy_o),   32'd0);
    check("async_reset_addr",   32'(bus_if.addr_o),   32'd0);
    bus_if.spi_cs_ni = 1'b1;
    @(negedge clk_sys_i);
    reset_i = 1'b0;
    bus_if.ack_i  = 1'b1;
    bus_if.data_i = 8'hAA;
    @(negedge clk_sys_i);
    bus_if.ack_i = 1'b0;
    @(negedge clk_sys_i);
    check("late_ack_strobe", 32'(bus_if.strobe_o),  32'd0);
    check("late_ack_tx",     32'(bus_if.tx_byte_o), 32'd0);
    check("late_ack_state",  32'(dut.state),        32'(IDLE));

    // Randomized frames against a command-level reference model.
    m_addr = 17'h0;
    m_data = 8'h00;
    m_tx   = 8'h00;
    for (int f = 0; f < 60; f++) begin
      cs_low();
      ncmd  = $urandom_range(1, 4);
      ended = 1'b0;
      for (int c = 0; c < ncmd && !ended; c++) begin
        k = $urandom_range(0, 5);
        case (k)
          0, 5:    op = 4'h8;
          1:       op = 4'h2;
          2:       op = 4'h3;
          3:       op = 4'h4;
          default: op = bad_ops[$urandom_range(0, 11)];
        endcase
        nargs = (op == 4'h8) ? 3 : (op == 4'h2) ? 2 : (op == 4'h4) ? 1 : 0;
        a16   = 1'($urandom);
        cmdb  = {op, 3'($urandom), a16};
        for (int j = 0; j < 3; j++) args[j] = 8'($urandom);
        send(cmdb);
        if (k == 4) begin
          nj = $urandom_range(0, 3);
          for (int j = 0; j < nj; j++) begin
            send(8'($urandom));
            check("rnd_err_no_strobe", 32'(bus_if.strobe_o), 32'd0);
          end
          check("rnd_err_state", 32'(dut.state), 32'(ERROR));
          ended = 1'b1;
        end else begin
          trunc = (nargs > 0) && ($urandom_range(0, 6) == 0);
          nsend = trunc ? $urandom_range(0, nargs - 1) : nargs;
          if (nargs > 0) check("rnd_no_strobe_cmd", 32'(bus_if.strobe_o), 32'd0);
          for (int j = 0; j < nsend; j++) begin
            send(args[j]);
            if (j < nargs - 1) check("rnd_no_strobe_arg", 32'(bus_if.strobe_o), 32'd0);
          end
          if (trunc) begin
            ended = 1'b1;
          end else begin
            case (op)
              4'h8: begin m_data = args[0]; m_addr = {a16, args[1], args[2]}; e_we = 1'b1; end
              4'h2: begin m_addr = {a16, args[0], args[1]}; e_we = 1'b0; end
              4'h3: begin m_addr = 17'((int'(m_addr) + 1) % 131072); e_we = 1'b0; end
              default: begin m_data = args[0]; m_addr = 17'((int'(m_addr) + 1) % 131072); e_we = 1'b1; end
            endcase
            delay   = $urandom_range(0, 4);
            rd      = 8'($urandom);
            cs_rise = (c == ncmd - 1) && (delay > 0) && ($urandom_range(0, 3) == 0);
            inject  = (delay > 0) && ($urandom_range(0, 1) == 1);
            serve_bus("rnd", m_addr, e_we, m_data, delay, rd, inject, cs_rise);
            if (!e_we) m_tx = rd;
            check("rnd_tx", 32'(bus_if.tx_byte_o), 32'(m_tx));
            if (cs_rise) ended = 1'b1;
          end
        end
      end
      if (bus_if.spi_cs_ni == 1'b0) cs_high();
      check("rnd_frame_idle",   32'(dut.state),       32'(IDLE));
      check("rnd_frame_strobe", 32'(bus_if.strobe_o), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_cmd_sequencer.md
SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 17, bus address width.
REQ-002 Parameter DATA_WIDTH, default 8, bus data width; SPI frame is fixed at 8 bits.
REQ-003 clk_sys_i  in  1  system clock; all logic on rising edge.
REQ-004 reset_i  in  1  reset, asynchronous, active-high.
REQ-005 spi_cs_ni  in  1  SPI chip select, already synchronized to clk_sys_i; low = transaction active.
REQ-006 rx_byte_i  in  8  byte received by spi_byte; valid only while rx_valid_i is high.
REQ-007 rx_valid_i  in  1  one-cycle pulse per completed SPI byte.
REQ-008 tx_byte_o  out  8  byte that spi_byte preloads for the next SPI frame.
REQ-009 addr_o  out  ADDR_WIDTH  bus address.
REQ-010 data_o  out  DATA_WIDTH  bus write data.
REQ-011 data_i  in  DATA_WIDTH  bus read data; valid in the cycle ack_i is high.
REQ-012 we_o  out  1  1 = write cycle, 0 = read cycle; qualified by strobe_o.
REQ-013 strobe_o  out  1  bus request; held high until ack_i.
REQ-014 ack_i  in  1  one-cycle bus completion.
REQ-015 busy_o  out  1  high while a bus cycle is outstanding.

Function
REQ-016 Command byte layout: opcode [7:4]; bit [0] = address bit 16; bits [3:1] are ignored.
REQ-017 Opcode 0x8 WRITE_AT takes 3 argument bytes (data, addr[15:8], addr[7:0]), then writes data to the address.
REQ-018 Opcode 0x2 READ_AT takes 2 argument bytes (addr[15:8], addr[7:0]), then reads from the address.
REQ-019 Opcode 0x3 READ_NEXT takes 0 argument bytes; addr_o increments by 1, then a read is issued.
REQ-020 Opcode 0x4 WRITE_NEXT takes 1 argument byte (data); addr_o increments by 1, then a write is issued.
REQ-021 Any other opcode moves the FSM to ERROR; rx bytes are ignored until spi_cs_ni rises.
REQ-022 FSM states: IDLE, CMD, ARG, BUS, DONE, ERROR.
REQ-023 IDLE -> CMD on spi_cs_ni falling.
REQ-024 CMD: on rx_valid_i, latch the opcode and the A16 bit, load the argument counter, and go to ARG; go to BUS if the count is 0.
REQ-025 ARG: each rx_valid_i shifts one byte into the data/address registers and decrements the counter; on the final byte go to BUS.
REQ-026 strobe_o asserts in the cycle after the final argument byte's rx_valid_i (READ_NEXT: after the command byte), i.e. 1-cycle latency.
REQ-027 BUS: strobe_o and we_o are held; on ack_i, strobe_o drops in the same cycle's next edge, and the FSM goes to DONE.
REQ-028 A read ack latches data_i into tx_byte_o on that edge.
REQ-029 ack_i in the same cycle strobe_o first rises is legal.
REQ-030 DONE: further rx_valid_i pulses are treated as a new command byte (go to CMD handling), so multiple commands can be chained within one CS frame.
REQ-031 Address arithmetic is ADDR_WIDTH bits, modulo: 0x1FFFF + 1 = 0x00000, no carry out.
REQ-032 tx_byte_o holds its value between loads and is unchanged by writes.
REQ-033 spi_cs_ni rising in CMD, ARG, DONE or ERROR returns to IDLE; partial arguments are discarded and no bus cycle is issued.
REQ-034 spi_cs_ni rising in BUS does not abort the bus cycle; the strobe completes on ack_i, any read data is still loaded, then the FSM goes to IDLE.
REQ-035 rx_valid_i arriving in BUS is dropped; the host must allow ≥1 SPI byte time for bus completion.

Reset
REQ-036 On reset_i: state=IDLE, strobe_o=0, we_o=0, busy_o=0, addr_o=0, data_o=0, tx_byte_o=0x00, argument counter=0.
REQ-037 Reset asserted mid-bus-cycle drops strobe_o immediately; a late ack_i outside BUS is ignored.

Structure
REQ-038 Package spi_cmd_pkg holds the opcode enum (WRITE_AT, READ_AT, READ_NEXT, WRITE_NEXT), the FSM state enum, and the per-opcode argument-count constants.
REQ-039 No sub-module is instantiated; spi_byte is instantiated beside this block in the parent.

Verification
REQ-040 Send CS low, 0x81 0x5A 0x12 0x34 -> one write: addr_o=0x11234, data_o=0x5A, we_o=1; strobe_o rises 1 cycle after the last rx_valid_i.
REQ-041 Send READ_AT 0x20 0x80 0x00 with data_i=0xC3 on ack -> strobe_o with we_o=0 at 0x08000; tx_byte_o=0xC3 after ack.
REQ-042 Send WRITE_AT to 0x1FFFF, then WRITE_NEXT 0x40 0x77 -> second write at addr_o=0x00000 with data 0x77.
REQ-043 Send 0x81 0x5A, then raise CS -> no strobe_o; next frame's READ_NEXT uses the previous address + 1.
REQ-044 Send opcode 0xF0 followed by 3 bytes -> no strobe_o; state=ERROR until CS rises, then IDLE.
REQ-045 Raise CS during BUS with ack delayed 5 cycles -> strobe_o is held until ack, then state=IDLE; assert reset_i mid-strobe -> strobe_o=0 asynchronously.
